quad_step_gen: RTL and testbench
================================

QUAD_STEP_GEN -- requirements
Module: quad_step_gen

Interface
REQ-001 The block SHALL have parameter PHASE_CYCLES, default 1000, meaning clock cycles each quadrature phase is held (legal range >=2).
REQ-002 The block SHALL have parameter POS_W, default 8, meaning width of the position counter.
REQ-003 Port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port step_req  input  1  request one detent step; level sampled every cycle.
REQ-006 Port step_dir  input  1  direction for step_req: 1 = clockwise, 0 = counter-clockwise.
REQ-007 Port rot_a  output  1  emulated encoder channel A, registered.
REQ-008 Port rot_b  output  1  emulated encoder channel B, registered.
REQ-009 Port busy  output  1  high while a step waveform is being driven.
REQ-010 Port step_done  output  1  one-cycle pulse in the final cycle of each step.
REQ-011 Port overflow  output  1  one-cycle pulse when a request is dropped.
REQ-012 Port position  output  POS_W  signed detent count, two's complement.

Function
REQ-013 The FSM SHALL have states IDLE, PH1, PH2, PH3, PH4, each PH state held exactly PHASE_CYCLES cycles by a phase counter.
REQ-014 (rot_a,rot_b) SHALL be 00 in IDLE and PH4; clockwise PH1/PH2/PH3 = 10/11/01; counter-clockwise PH1/PH2/PH3 = 01/11/10.
REQ-015 Only one of rot_a, rot_b SHALL change on any clock edge (Gray sequence, no glitches).
REQ-016 A request SHALL be accepted when step_req=1 in IDLE; direction latched the same edge; PH1 pattern and busy=1 visible the next cycle.
REQ-017 busy SHALL be 1 in PH1..PH4 and 0 in IDLE; one step occupies exactly 4*PHASE_CYCLES cycles.
REQ-018 step_done SHALL be 1 only during the last cycle of PH4; position SHALL change by +1 (cw) or -1 (ccw) on the edge ending that cycle.
REQ-019 position SHALL wrap modulo 2^POS_W (0x7F+1 -> 0x80, 0x00-1 -> 0xFF for POS_W=8) with no saturation or flag.
REQ-020 A one-entry pending register (valid + dir) SHALL capture step_req asserted while busy=1 and pending empty.
REQ-021 step_req while busy=1 and pending full SHALL be dropped, overflow pulsed that cycle, pending unchanged.
REQ-022 After PH4 ends, a valid pending step SHALL start PH1 on the next cycle with no IDLE cycle (busy stays 1) and pending SHALL clear.
REQ-023 step_req in the last PH4 cycle: pending empty -> request starts next cycle directly; pending full -> pending starts next, new request enters pending, no overflow.
REQ-024 step_req held high SHALL count as one new request per cycle it is sampled (level, not edge); requesters pulse for one cycle per step.
REQ-025 step_dir SHALL be ignored except on the cycle a request is accepted or captured.

Reset
REQ-026 rst=1 at a posedge SHALL force IDLE, rot_a=0, rot_b=0, busy=0, step_done=0, overflow=0, position=0, pending cleared, phase counter=0.
REQ-027 rst SHALL override every other input, including mid-step; a partial step SHALL NOT update position.
REQ-028 step_req coincident with rst SHALL be ignored; first acceptance possible the cycle after rst deasserts.

Verification (PHASE_CYCLES=4, POS_W=8)
REQ-029 Single cw pulse at t0 from IDLE -> (a,b)=10 t0+1..4, 11 t0+5..8, 01 t0+9..12, 00 t0+13..16, step_done at t0+16, position=1 and busy=0 at t0+17.
REQ-030 Single ccw pulse from position 0 -> sequence 01,11,10,00 at same timing; position=0xFF after step_done.
REQ-031 Three pulses on consecutive cycles while idle -> first runs, second pending, third overflow pulse; 32 busy cycles back-to-back; position=+2.
REQ-032 Request in last PH4 cycle with pending full -> no overflow, three steps run back-to-back, no IDLE gap, position +3.
REQ-033 rst asserted during PH2 of a cw step with pending valid -> next cycle (a,b)=00, busy=0, position unchanged at 0, no later step runs.
REQ-034 127 cw steps then one more -> position 0x7F then 0x80; monitor confirms only one channel toggles per edge throughout.

Source files
------------

// File: rtl/quad_step_gen.sv
// Quadrature encoder emulator: each requested detent step drives a four-phase
// Gray sequence on rot_a/rot_b, with a one-deep pending slot and a wrapping position count.
module quad_step_gen #(
    parameter int PHASE_CYCLES = 1000,
    parameter int POS_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_req,
    input  logic             step_dir,
    output logic             rot_a,
    output logic             rot_b,
    output logic             busy,
    output logic             step_done,
    output logic             overflow,
    output logic [POS_W-1:0] position
);

    localparam int               CNT_W    = $clog2(PHASE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PH1  = 3'd1,
        S_PH2  = 3'd2,
        S_PH3  = 3'd3,
        S_PH4  = 3'd4
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dir;
    logic               r_pend_vld;
    logic               r_pend_dir;
    logic               r_rot_a;
    logic               r_rot_b;
    logic               r_busy;
    logic               r_step_done;
    logic [POS_W-1:0]   r_position;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_dir_nxt;
    logic               w_pend_vld_nxt;
    logic               w_pend_dir_nxt;
    logic [POS_W-1:0]   w_position_nxt;
    logic [1:0]         w_ab_nxt;
    logic               w_phase_end;
    logic               w_handoff;
    logic               w_busy_req;

    // Channel pattern per phase; clockwise leads with A, counter-clockwise with B.
    function automatic logic [1:0] phase_ab(input state_t s, input logic dir);
        logic [1:0] ab;
        case (s)
            S_PH1:   ab = dir ? 2'b10 : 2'b01;
            S_PH2:   ab = 2'b11;
            S_PH3:   ab = dir ? 2'b01 : 2'b10;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    assign w_phase_end = (r_state != S_IDLE) && (r_cnt == CNT_LAST);
    assign w_handoff   = (r_state == S_PH4) && w_phase_end;
    assign w_busy_req  = step_req && (r_state != S_IDLE) && !w_handoff;
    assign w_ab_nxt    = phase_ab(w_state_nxt, w_dir_nxt);

    // Next-state, phase counter, pending slot and position update
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dir_nxt      = r_dir;
        w_position_nxt = r_position;
        if (w_busy_req && !r_pend_vld) begin
            w_pend_vld_nxt = 1'b1;
            w_pend_dir_nxt = step_dir;
        end else begin
            w_pend_vld_nxt = r_pend_vld;
            w_pend_dir_nxt = r_pend_dir;
        end
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (step_req) begin
                    w_state_nxt = S_PH1;
                    w_dir_nxt   = step_dir;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PH1, S_PH2, S_PH3: begin
                if (w_phase_end) begin
                    w_state_nxt = state_t'(r_state + 3'd1);
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PH4: begin
                if (w_phase_end) begin
                    w_cnt_nxt      = '0;
                    w_position_nxt = r_dir ? (r_position + POS_W'(1)) : (r_position - POS_W'(1));
                    // Pending step goes first; a request arriving now refills the slot.
                    if (r_pend_vld) begin
                        w_state_nxt    = S_PH1;
                        w_dir_nxt      = r_pend_dir;
                        w_pend_vld_nxt = step_req;
                        w_pend_dir_nxt = step_req ? step_dir : r_pend_dir;
                    end else if (step_req) begin
                        w_state_nxt = S_PH1;
                        w_dir_nxt   = step_dir;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and registered outputs, all derived from next-state values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dir       <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_dir  <= 1'b0;
            r_rot_a     <= 1'b0;
            r_rot_b     <= 1'b0;
            r_busy      <= 1'b0;
            r_step_done <= 1'b0;
            r_position  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dir       <= w_dir_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_dir  <= w_pend_dir_nxt;
            r_rot_a     <= w_ab_nxt[1];
            r_rot_b     <= w_ab_nxt[0];
            r_busy      <= (w_state_nxt != S_IDLE);
            r_step_done <= (w_state_nxt == S_PH4) && (w_cnt_nxt == CNT_LAST);
            r_position  <= w_position_nxt;
        end
    end

    // Overflow must flag the very cycle the request is dropped, so it is decoded directly.
    assign overflow  = w_busy_req && r_pend_vld && !rst;
    assign rot_a     = r_rot_a;
    assign rot_b     = r_rot_b;
    assign busy      = r_busy;
    assign step_done = r_step_done;
    assign position  = r_position;

endmodule

// File: tb/tb_quad_step_gen.sv
// Randomised scoreboard bench for quad_step_gen: a schedule-of-steps model predicts
// step completions, drops, channel patterns and position.
module tb_quad_step_gen;

    localparam int P  = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          step_req = 1'b0;
    logic          step_dir = 1'b0;
    logic          rot_a, rot_b, busy, step_done, overflow;
    logic [PW-1:0] position;

    quad_step_gen #(.PHASE_CYCLES(P), .POS_W(PW)) dut (
        .clk(clk), .rst(rst), .step_req(step_req), .step_dir(step_dir),
        .rot_a(rot_a), .rot_b(rot_b), .busy(busy), .step_done(step_done),
        .overflow(overflow), .position(position)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    // One scheduled step: active cycles start..done, truncated at kill by a reset.
    typedef struct {
        int   start;
        int   done;
        int   kill;
        logic dir;
        logic alive;
    } step_t;

    step_t         sched[$];
    int            exp_done_q[$];
    int            exp_ovf_q[$];
    logic [PW-1:0] exp_pos = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    function automatic logic [1:0] exp_ab(input int ph, input logic dir);
        case (ph)
            0:       return dir ? 2'b10 : 2'b01;
            1:       return 2'b11;
            2:       return dir ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // A request at cycle t: at most two live steps may remain unfinished after t.
    task automatic model_req(input int t, input logic d);
        int    n;
        int    last;
        step_t e;
        n    = 0;
        last = -1;
        for (int i = 0; i < sched.size(); i++) begin
            if (sched[i].alive) begin
                if (sched[i].done > t) n++;
                if (sched[i].done > last) last = sched[i].done;
            end
        end
        if (n >= 2) begin
            exp_ovf_q.push_back(t);
        end else begin
            e.done  = ((last > t) ? last : t) + 4 * P;
            e.start = e.done - 4 * P + 1;
            e.kill  = 1 << 30;
            e.dir   = d;
            e.alive = 1'b1;
            sched.push_back(e);
            exp_done_q.push_back(e.done);
        end
    endtask

    task automatic model_reset(input int t);
        for (int i = 0; i < sched.size(); i++) begin
            if (sched[i].kill > t) sched[i].kill = t;
            sched[i].alive = 1'b0;
        end
        while (exp_done_q.size() > 0 && exp_done_q[$] > t) void'(exp_done_q.pop_back());
    endtask

    task automatic drive(input logic req, input logic d, input logic r);
        @(posedge clk);
        #1;
        step_req = req;
        step_dir = d;
        rst      = r;
        if (r) model_reset(cyc);
        else if (req) model_req(cyc, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: per-cycle expectations plus scoreboard pops on DUT events.
    logic [1:0] m_prev_ab = 2'b00;
    bit         m_have_prev = 1'b0;
    bit         m_prev_rst = 1'b0;
    int         m_c, m_chg;
    logic       m_busy, m_done, m_dir;
    logic [1:0] m_ab;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                m_c = cyc; m_busy = 1'b0; m_done = 1'b0; m_dir = 1'b0; m_ab = 2'b00;
                for (int i = 0; i < sched.size(); i++) begin
                    if (sched[i].start <= m_c && m_c <= sched[i].done && m_c <= sched[i].kill) begin
                        m_busy = 1'b1;
                        m_ab   = exp_ab((m_c - sched[i].start) / P, sched[i].dir);
                        m_done = (m_c == sched[i].done);
                        m_dir  = sched[i].dir;
                    end
                end
                chk("busy", int'(busy), int'(m_busy));
                chk("rot_ab", int'({rot_a, rot_b}), int'(m_ab));
                chk("step_done_level", int'(step_done), int'(m_done));
                chk("position", int'(position), int'(exp_pos));
                if (step_done) begin
                    if (exp_done_q.size() == 0) chk("step_done_unexpected", int'(step_done), 0);
                    else chk("step_done_cycle", m_c, exp_done_q.pop_front());
                end else if (exp_done_q.size() > 0 && exp_done_q[0] <= m_c) begin
                    chk("step_done_missing", int'(step_done), 1);
                    void'(exp_done_q.pop_front());
                end
                if (overflow) begin
                    if (exp_ovf_q.size() == 0) chk("overflow_unexpected", int'(overflow), 0);
                    else chk("overflow_cycle", m_c, exp_ovf_q.pop_front());
                end else if (exp_ovf_q.size() > 0 && exp_ovf_q[0] <= m_c) begin
                    chk("overflow_missing", int'(overflow), 1);
                    void'(exp_ovf_q.pop_front());
                end
                if (m_have_prev && !m_prev_rst) begin
                    m_chg = int'(m_prev_ab[1] != rot_a) + int'(m_prev_ab[0] != rot_b);
                    chk("gray_one_bit", int'(m_chg <= 1), 1);
                end
                if (rst) exp_pos = '0;
                else if (m_done) exp_pos = m_dir ? exp_pos + 8'd1 : exp_pos - 8'd1;
                m_prev_ab   = {rot_a, rot_b};
                m_prev_rst  = rst;
                m_have_prev = 1'b1;
            end
        end
    end

    initial begin
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        idle(3);
        // single ccw from 0, then single cw
        drive(1'b1, 1'b0, 1'b0); idle(20);
        drive(1'b1, 1'b1, 1'b0); idle(20);
        // three back-to-back pulses: run, pending, overflow
        repeat (3) drive(1'b1, 1'b1, 1'b0);
        idle(40);
        // request in the last PH4 cycle with pending full
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        idle(14);
        drive(1'b1, 1'b1, 1'b0);
        idle(60);
        // reset during PH2 with a pending step queued
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        idle(5);
        drive(1'b1, 1'b0, 1'b1);
        idle(40);
        // wrap across the signed boundary
        repeat (127) begin
            drive(1'b1, 1'b1, 1'b0);
            idle(16);
        end
        idle(1);
        chk("pos_after_127", int'(position), 8'h7F);
        drive(1'b1, 1'b1, 1'b0);
        idle(17);
        chk("pos_after_128", int'(position), 8'h80);
        // randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 399) == 0));
        end
        idle(80);
        chk("done_queue_empty", exp_done_q.size(), 0);
        chk("ovf_queue_empty", exp_ovf_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
